// File: rtl/cpu_pkg.sv
// Shared types and default widths for the SAP-style CPU memory-address path.
//   seq_state_e : programming sequencer state (RUN=0, 2 bits)
//   *_DEF       : default parameter values used by mar_prog_sequencer
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF      = 4;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_P_IDLE  = 2'd1,
        ST_P_WRITE = 2'd2,
        ST_P_INC   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous front-panel input, plus a
// registered rising-edge detector.
//   clk, clr : clock, asynchronous active-high reset
//   din      : asynchronous input
//   level    : synchronised level (STAGES edges after din)
//   pulse    : one-cycle pulse, STAGES+1 edges after a rising din
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              pulse_q, pulse_d;

    // Shift chain plus edge compare; the pulse is registered so that it
    // leaves this block on a flop rather than through gates.
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], din};
        prev_d  = sync_q[STAGES-1];
        pulse_d = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign pulse = pulse_q;

endmodule

// File: rtl/mar_prog_sequencer.sv
// Memory address register with manual front-panel programming sequencer.
// Run mode: mem_addr loads from bus on reg_en. Program mode: RAM is driven
// from prog_addr (loaded from DIP switches) and the WRITE button becomes a
// single-cycle ram_we, optionally followed by an address increment.
//   clk, clr            : clock, asynchronous active-high reset
//   prog_en             : program-mode switch (async)
//   reg_en, bus         : run-mode address load
//   addr_sw, data_sw    : DIP switches
//   load_btn, write_btn : front-panel buttons (async)
//   auto_inc            : increment prog_addr after each write
//   addr, ram_we, ram_wdata : RAM interface
//   prog, busy          : status decoded from state
module mar_prog_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              prog_en,
    input  logic              reg_en,
    input  logic [ADDR_W-1:0] bus,
    input  logic [ADDR_W-1:0] addr_sw,
    input  logic [DATA_W-1:0] data_sw,
    input  logic              load_btn,
    input  logic              write_btn,
    input  logic              auto_inc,
    output logic [ADDR_W-1:0] addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              prog,
    output logic              busy
);

    logic prog_s, load_p, write_p;
    logic prog_pulse_unused, load_level_unused, write_level_unused;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_prog (
        .clk   (clk),
        .clr   (clr),
        .din   (prog_en),
        .level (prog_s),
        .pulse (prog_pulse_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk   (clk),
        .clr   (clr),
        .din   (load_btn),
        .level (load_level_unused),
        .pulse (load_p)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_write (
        .clk   (clk),
        .clr   (clr),
        .din   (write_btn),
        .level (write_level_unused),
        .pulse (write_p)
    );

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_RUN;
            mem_addr_q  <= '0;
            prog_addr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            prog_addr_q <= prog_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Next-state and register updates. Pulses are only consumed in P_IDLE,
    // so anything arriving in WRITE/INC is dropped rather than queued.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        prog_addr_d = prog_addr_q;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            ST_RUN: begin
                if (reg_en) begin
                    mem_addr_d = bus;
                end
                if (prog_s) begin
                    state_d     = ST_P_IDLE;
                    prog_addr_d = addr_sw;
                end
            end
            ST_P_IDLE: begin
                // Write has priority; a simultaneous load is discarded.
                if (write_p) begin
                    state_d     = ST_P_WRITE;
                    ram_wdata_d = data_sw;
                end else if (load_p) begin
                    prog_addr_d = addr_sw;
                end else if (!prog_s) begin
                    state_d = ST_RUN;
                end
            end
            ST_P_WRITE: begin
                state_d = auto_inc ? ST_P_INC : ST_P_IDLE;
            end
            ST_P_INC: begin
                prog_addr_d = prog_addr_q + ADDR_W'(1);
                state_d     = ST_P_IDLE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are decoded from flops only; clr clears state_q asynchronously,
    // so ram_we drops without waiting for a clock.
    always_comb begin
        addr      = (state_q == ST_RUN) ? mem_addr_q : prog_addr_q;
        ram_we    = (state_q == ST_P_WRITE);
        ram_wdata = ram_wdata_q;
        prog      = (state_q != ST_RUN);
        busy      = (state_q == ST_P_WRITE) || (state_q == ST_P_INC);
    end

endmodule

// File: tb/tb_mar_prog_sequencer.sv
// Directed self-checking bench for mar_prog_sequencer (default parameters).
module tb_mar_prog_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       prog_en;
    logic       reg_en;
    logic [3:0] bus;
    logic [3:0] addr_sw;
    logic [7:0] data_sw;
    logic       load_btn;
    logic       write_btn;
    logic       auto_inc;
    logic [3:0] addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic       prog;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    mar_prog_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .prog_en   (prog_en),
        .reg_en    (reg_en),
        .bus       (bus),
        .addr_sw   (addr_sw),
        .data_sw   (data_sw),
        .load_btn  (load_btn),
        .write_btn (write_btn),
        .auto_inc  (auto_inc),
        .addr      (addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .prog      (prog),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        clr = 1'b1; prog_en = 1'b0; reg_en = 1'b1; bus = 4'hA;
        addr_sw = 4'h0; data_sw = 8'h00; load_btn = 1'b0; write_btn = 1'b0;
        auto_inc = 1'b0;

        // Reset state held under clr
        ticks(2);
        check("rst_addr",  32'(addr), 32'h0);
        check("rst_we",    32'(ram_we), 32'h0);
        check("rst_wdata", 32'(ram_wdata), 32'h0);
        check("rst_prog",  32'(prog), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);

        // Release clr between edges; next edge loads bus
        clr = 1'b0;
        #1;
        check("rel_addr0", 32'(addr), 32'h0);
        tick();
        check("run_addrA", 32'(addr), 32'hA);
        check("run_prog",  32'(prog), 32'h0);
        check("run_we",    32'(ram_we), 32'h0);
        reg_en = 1'b0;

        // Enter program mode: prog rises on the third edge
        addr_sw = 4'h3; prog_en = 1'b1;
        ticks(2);
        check("prog_early", 32'(prog), 32'h0);
        tick();
        check("prog_rise", 32'(prog), 32'h1);
        check("prog_addr3", 32'(addr), 32'h3);

        // reg_en ignored in program mode
        reg_en = 1'b1; bus = 4'h5;
        tick();
        reg_en = 1'b0;
        check("regen_ign", 32'(addr), 32'h3);

        // Write 5C at 3 with auto-increment
        data_sw = 8'h5C; auto_inc = 1'b1; write_btn = 1'b1;
        ticks(3);
        check("w1_pre_we", 32'(ram_we), 32'h0);
        tick();
        check("w1_we",    32'(ram_we), 32'h1);
        check("w1_addr",  32'(addr), 32'h3);
        check("w1_wdata", 32'(ram_wdata), 32'h5C);
        check("w1_busy",  32'(busy), 32'h1);
        write_btn = 1'b0;
        tick();
        check("w1_inc_we",   32'(ram_we), 32'h0);
        check("w1_inc_busy", 32'(busy), 32'h1);
        check("w1_inc_addr", 32'(addr), 32'h3);
        tick();
        check("w1_post_addr", 32'(addr), 32'h4);
        check("w1_post_busy", 32'(busy), 32'h0);
        ticks(3);

        // Load F, then write with wrap to 0
        addr_sw = 4'hF; load_btn = 1'b1;
        ticks(4);
        check("load_F", 32'(addr), 32'hF);
        load_btn = 1'b0;
        ticks(3);
        data_sw = 8'hA5; write_btn = 1'b1;
        ticks(4);
        check("w2_we",   32'(ram_we), 32'h1);
        check("w2_addr", 32'(addr), 32'hF);
        check("w2_wdata", 32'(ram_wdata), 32'hA5);
        write_btn = 1'b0;
        ticks(2);
        check("w2_wrap", 32'(addr), 32'h0);
        ticks(3);

        // Load 2
        addr_sw = 4'h2; load_btn = 1'b1;
        ticks(4);
        check("load_2", 32'(addr), 32'h2);
        load_btn = 1'b0;
        ticks(3);

        // Simultaneous load+write: write wins; second write edge dropped in INC
        addr_sw = 4'h7; data_sw = 8'h3C; load_btn = 1'b1; write_btn = 1'b1;
        tick();
        write_btn = 1'b0;
        tick();
        write_btn = 1'b1;
        tick();
        tick();
        check("col_we",   32'(ram_we), 32'h1);
        check("col_addr", 32'(addr), 32'h2);
        check("col_wdata", 32'(ram_wdata), 32'h3C);
        tick();
        check("col_inc_we", 32'(ram_we), 32'h0);
        tick();
        check("col_noload", 32'(addr), 32'h3);
        check("col_idle_we", 32'(ram_we), 32'h0);
        tick();
        check("col_drop1", 32'(ram_we), 32'h0);
        tick();
        check("col_drop2", 32'(ram_we), 32'h0);
        check("col_drop_busy", 32'(busy), 32'h0);
        load_btn = 1'b0; write_btn = 1'b0;
        ticks(4);

        // prog_en falls during P_WRITE: INC completes, then RUN
        data_sw = 8'h11; write_btn = 1'b1;
        ticks(4);
        check("pe_we",   32'(ram_we), 32'h1);
        check("pe_addr", 32'(addr), 32'h3);
        prog_en = 1'b0; write_btn = 1'b0;
        tick();
        check("pe_inc_busy", 32'(busy), 32'h1);
        tick();
        check("pe_idle_prog", 32'(prog), 32'h1);
        check("pe_idle_addr", 32'(addr), 32'h4);
        tick();
        check("pe_run_prog", 32'(prog), 32'h0);
        check("pe_memaddr",  32'(addr), 32'hA);
        ticks(2);

        // clr during P_WRITE aborts immediately
        addr_sw = 4'h9; prog_en = 1'b1;
        ticks(3);
        check("re_prog_addr", 32'(addr), 32'h9);
        data_sw = 8'h77; write_btn = 1'b1;
        ticks(4);
        check("clr_pre_we", 32'(ram_we), 32'h1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_we",    32'(ram_we), 32'h0);
        check("clr_prog",  32'(prog), 32'h0);
        check("clr_busy",  32'(busy), 32'h0);
        check("clr_addr",  32'(addr), 32'h0);
        check("clr_wdata", 32'(ram_wdata), 32'h0);
        prog_en = 1'b0; write_btn = 1'b0;
        tick();
        clr = 1'b0;
        ticks(2);
        check("post_clr_addr", 32'(addr), 32'h0);
        check("post_clr_prog", 32'(prog), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
